// File: rtl/char_mem_pkg.sv
// Shared types and constants for the text-mode character memory.
package char_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } clr_state_e;

  localparam logic [7:0]  SPACE_CHAR     = 8'h20;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BLINK_W        = 24;

endpackage

// File: rtl/char_mem_ram.sv
// True-dual-port 32-bit word store: port A read-only, port B byte-enable write / read.
module char_mem_ram
  import char_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 480,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_en,
  input  logic [AW-1:0] a_addr,
  output logic [31:0]   a_rdata,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [3:0]    b_be,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata,
  output logic [31:0]   b_rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (b_en && b_we) begin
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
        if (b_be[i]) mem_q[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
      end
    end
  end

  // Reads sample the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_en) a_rdata <= mem_q[a_addr];
      if (b_en && !b_we) b_rdata <= mem_q[b_addr];
    end
  end

endmodule

// File: rtl/char_mem_ctrl.sv
// Character memory controller: scrolled video read port, 32-bit CPU port, clear engine.
// Optional blinking cursor overlay when CMEM_CURSOR_EN is defined.
module char_mem_ctrl
  import char_mem_pkg::*;
#(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 24,
  parameter int unsigned CW   = 7,
  parameter int unsigned RW   = 5,
  parameter int unsigned AW   = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vid_en,
  input  logic [CW-1:0] vid_col,
  input  logic [RW-1:0] vid_row,
  output logic [7:0]    vid_char,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [3:0]    cpu_be,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_ready,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          scroll_we,
  input  logic [RW-1:0] scroll_in,
  input  logic          clr_req,
  input  logic [7:0]    clr_char,
`ifdef CMEM_CURSOR_EN
  input  logic          cur_en,
  input  logic [CW-1:0] cur_col,
  input  logic [RW-1:0] cur_row,
`endif
  output logic          clr_busy
);

  localparam int unsigned WORDS = COLS * ROWS / BYTES_PER_WORD;
  localparam int unsigned KW    = AW + 2;

  clr_state_e    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    fill_q, fill_d;
  logic [RW-1:0] scroll_q;
  logic          vid_valid_q, vid_oor_q, cpu_rvalid_q, rd_oob_q;
  logic [1:0]    vid_sel_q;

  logic [RW:0]   row_sum;
  logic [KW-1:0] vid_k;
  logic          vid_in_range, cpu_xfer, cpu_addr_ok;
  logic          b_en, b_we;
  logic [3:0]    b_be;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_wdata, a_rdata, b_rdata;

  always_comb begin
    row_sum = {1'b0, vid_row} + {1'b0, scroll_q};
    if (row_sum >= (RW+1)'(ROWS)) row_sum = row_sum - (RW+1)'(ROWS);
    vid_k        = KW'(row_sum[RW-1:0]) * KW'(COLS) + KW'(vid_col);
    vid_in_range = ({1'b0, vid_col} < (CW+1)'(COLS)) && ({1'b0, vid_row} < (RW+1)'(ROWS));
  end

  assign cpu_ready   = reset_n && (state_q == IDLE) && !clr_req;
  assign cpu_xfer    = cpu_req && cpu_ready;
  assign cpu_addr_ok = {1'b0, cpu_addr} < (AW+1)'(WORDS);
  assign clr_busy    = (state_q == CLEAR);

  // Port B is owned by the clear engine while clearing, otherwise by the CPU.
  always_comb begin
    b_en    = cpu_xfer && cpu_addr_ok;
    b_we    = cpu_we;
    b_be    = cpu_be;
    b_addr  = cpu_addr;
    b_wdata = cpu_wdata;
    if (state_q == CLEAR) begin
      b_en    = 1'b1;
      b_we    = 1'b1;
      b_be    = '1;
      b_addr  = ptr_q;
      b_wdata = {BYTES_PER_WORD{fill_q}};
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: if (clr_req) begin
        fill_d  = clr_char;
        ptr_d   = '0;
        state_d = CLEAR;
      end
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(WORDS - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      fill_q       <= '0;
      scroll_q     <= '0;
      vid_valid_q  <= 1'b0;
      vid_oor_q    <= 1'b0;
      vid_sel_q    <= '0;
      cpu_rvalid_q <= 1'b0;
      rd_oob_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      fill_q       <= fill_d;
      vid_valid_q  <= vid_en;
      cpu_rvalid_q <= cpu_xfer && !cpu_we;
      if (scroll_we && ({1'b0, scroll_in} < (RW+1)'(ROWS))) scroll_q <= scroll_in;
      if (vid_en) begin
        vid_oor_q <= !vid_in_range;
        vid_sel_q <= vid_k[1:0];
      end
      if (cpu_xfer && !cpu_we) rd_oob_q <= !cpu_addr_ok;
    end
  end

`ifdef CMEM_CURSOR_EN
  logic [BLINK_W-1:0] blink_q;
  logic               cur_hit_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_q   <= '0;
      cur_hit_q <= 1'b0;
    end else begin
      blink_q <= blink_q + BLINK_W'(1);
      if (vid_en) cur_hit_q <= cur_en && blink_q[BLINK_W-1] &&
                               (vid_col == cur_col) && (vid_row == cur_row);
    end
  end
`endif

  always_comb begin
    vid_char = vid_oor_q ? SPACE_CHAR : a_rdata[{vid_sel_q, 3'b000} +: 8];
`ifdef CMEM_CURSOR_EN
    if (cur_hit_q) vid_char[7] = ~vid_char[7];
`endif
  end

  assign vid_valid  = vid_valid_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = rd_oob_q ? '0 : b_rdata;

  char_mem_ram #(
    .DEPTH (WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_n),
    .a_en    (vid_en && vid_in_range),
    .a_addr  (vid_k[KW-1:2]),
    .a_rdata (a_rdata),
    .b_en    (b_en),
    .b_we    (b_we),
    .b_be    (b_be),
    .b_addr  (b_addr),
    .b_wdata (b_wdata),
    .b_rdata (b_rdata)
  );

endmodule

// File: tb/tb_char_mem_ctrl.sv
// Self-checking bench for char_mem_ctrl: directed cases plus randomized traffic vs. a reference model.
module tb_char_mem_ctrl;

  localparam int COLS = 80;
  localparam int ROWS = 24;
  localparam int CW   = 7;
  localparam int RW   = 5;
  localparam int AW   = 9;
  localparam int N    = COLS * ROWS / 4;

  logic          clk, reset_n;
  logic          vid_en;
  logic [CW-1:0] vid_col;
  logic [RW-1:0] vid_row;
  logic [7:0]    vid_char;
  logic          vid_valid;
  logic          cpu_req, cpu_we;
  logic [3:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata, cpu_rdata;
  logic          cpu_ready, cpu_rvalid;
  logic          scroll_we;
  logic [RW-1:0] scroll_in;
  logic          clr_req;
  logic [7:0]    clr_char;
  logic          clr_busy;
`ifdef CMEM_CURSOR_EN
  logic          cur_en;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
`endif

  char_mem_ctrl #(
    .COLS (COLS),
    .ROWS (ROWS),
    .CW   (CW),
    .RW   (RW),
    .AW   (AW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vid_en     (vid_en),
    .vid_col    (vid_col),
    .vid_row    (vid_row),
    .vid_char   (vid_char),
    .vid_valid  (vid_valid),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_be     (cpu_be),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .scroll_we  (scroll_we),
    .scroll_in  (scroll_in),
    .clr_req    (clr_req),
    .clr_char   (clr_char),
`ifdef CMEM_CURSOR_EN
    .cur_en     (cur_en),
    .cur_col    (cur_col),
    .cur_row    (cur_row),
`endif
    .clr_busy   (clr_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [31:0] mem_m [N];
  int          scroll_m;
  int          clr_pos;      // -1 idle, 0..N-1 next word to clear, N = done cycle
  logic [7:0]  fill_m;
  logic        exp_vv, exp_rv;
  logic [7:0]  exp_vc;
  logic [31:0] exp_rd;
  bit          force_blink;
  bit          chk_en;
  int          checks, failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] vid_model(input int col, input int row);
    int k;
    logic [31:0] w;
    if (col >= COLS || row >= ROWS) return 8'h20;
    k = ((row + scroll_m) % ROWS) * COLS + col;
    w = mem_m[k / 4];
    return w[8*(k % 4) +: 8];
  endfunction

  initial begin
    clr_pos = -1;
    scroll_m = 0;
    exp_vv = 0; exp_vc = 0; exp_rv = 0; exp_rd = 0;
    for (int i = 0; i < N; i++) mem_m[i] = '0;
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        clr_pos = -1; scroll_m = 0;
        exp_vv = 0; exp_vc = 0; exp_rv = 0; exp_rd = 0;
      end else begin
        bit rdy;
        exp_vv = vid_en;
        if (vid_en) begin
          exp_vc = vid_model(int'(vid_col), int'(vid_row));
`ifdef CMEM_CURSOR_EN
          if (cur_en && force_blink && vid_col == cur_col && vid_row == cur_row) exp_vc ^= 8'h80;
`endif
        end
        rdy = (clr_pos == -1) && !clr_req;
        exp_rv = 1'b0;
        if (cpu_req && rdy) begin
          if (cpu_we) begin
            if (int'(cpu_addr) < N)
              for (int b = 0; b < 4; b++)
                if (cpu_be[b]) mem_m[cpu_addr][8*b +: 8] = cpu_wdata[8*b +: 8];
          end else begin
            exp_rv = 1'b1;
            exp_rd = (int'(cpu_addr) < N) ? mem_m[cpu_addr] : 32'h0;
          end
        end
        if (scroll_we && int'(scroll_in) < ROWS) scroll_m = int'(scroll_in);
        if (clr_pos == -1) begin
          if (clr_req) begin fill_m = clr_char; clr_pos = 0; end
        end else if (clr_pos < N) begin
          mem_m[clr_pos] = {4{fill_m}};
          clr_pos++;
        end else begin
          clr_pos = -1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && chk_en) begin
        check("vid_valid", {31'b0, vid_valid}, {31'b0, exp_vv});
        if (exp_vv) check("vid_char", {24'b0, vid_char}, {24'b0, exp_vc});
        check("cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, exp_rv});
        if (exp_rv) check("cpu_rdata", cpu_rdata, exp_rd);
        check("cpu_ready", {31'b0, cpu_ready}, {31'b0, (clr_pos == -1) && !clr_req});
        check("clr_busy", {31'b0, clr_busy}, {31'b0, (clr_pos >= 0) && (clr_pos < N)});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_be = be; cpu_wdata = d;
    tick;
    cpu_req = 0; cpu_we = 0;
  endtask

  task automatic cpu_rd(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    cpu_req = 1; cpu_we = 0; cpu_addr = a;
    tick;
    cpu_req = 0;
    check({name, "_rvalid"}, {31'b0, cpu_rvalid}, 32'h1);
    check(name, cpu_rdata, exp);
  endtask

  task automatic vid_read(input string name, input logic [CW-1:0] c, input logic [RW-1:0] r,
                          input logic [7:0] exp);
    vid_en = 1; vid_col = c; vid_row = r;
    tick;
    vid_en = 0;
    check({name, "_valid"}, {31'b0, vid_valid}, 32'h1);
    check(name, {24'b0, vid_char}, {24'b0, exp});
  endtask

  task automatic set_scroll(input logic [RW-1:0] s);
    scroll_we = 1; scroll_in = s;
    tick;
    scroll_we = 0;
  endtask

  task automatic wait_idle;
    int g;
    g = 0;
    while (!cpu_ready && g < 2000) begin tick; g++; end
    check("idle_timeout", {31'b0, cpu_ready}, 32'h1);
  endtask

  initial begin
    int busy_cnt, ready_bad, g;
    reset_n = 0; chk_en = 0; force_blink = 0;
    vid_en = 0; vid_col = '0; vid_row = '0;
    cpu_req = 0; cpu_we = 0; cpu_be = '0; cpu_addr = '0; cpu_wdata = '0;
    scroll_we = 0; scroll_in = '0; clr_req = 0; clr_char = '0;
`ifdef CMEM_CURSOR_EN
    cur_en = 0; cur_col = '0; cur_row = '0;
`endif
    checks = 0; failures = 0;
    repeat (3) tick;
    check("rst_vid_char", {24'b0, vid_char}, 32'h0);
    check("rst_vid_valid", {31'b0, vid_valid}, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
    check("rst_cpu_ready", {31'b0, cpu_ready}, 32'h0);
    check("rst_clr_busy", {31'b0, clr_busy}, 32'h0);
    reset_n = 1;
    tick;
    chk_en = 1;

    // Bring the array to a known state.
    clr_req = 1; clr_char = 8'h00;
    tick;
    clr_req = 0;
    wait_idle;

    cpu_wr(0, 4'hF, 32'h44434241);
    for (int i = 0; i < 4; i++) vid_read("vid_row0", CW'(i), 0, 8'h41 + 8'(i));

    cpu_wr(0, 4'b0100, 32'h00580000);
    cpu_rd("rd_be", 0, 32'h44584241);
    tick;
    check("rvalid_pulse", {31'b0, cpu_rvalid}, 32'h0);

    for (int w = 20; w < 40; w++) cpu_wr(AW'(w), 4'hF, 32'h42424242);
    set_scroll(1);
    vid_read("scroll1", 0, 0, 8'h42);
    set_scroll(23);
    vid_read("scroll_wrap", 0, 1, 8'h41);
    set_scroll(24);
    vid_read("scroll_ignored", 0, 1, 8'h41);
    vid_read("col_oob", 80, 0, 8'h20);
    vid_read("row_oob", 0, 24, 8'h20);
    set_scroll(0);

    cpu_wr(480, 4'hF, 32'hDEADBEEF);
    cpu_rd("rd_oob480", 480, 32'h0);
    cpu_rd("rd_oob511", 511, 32'h0);

    // Reset in the middle of a clear.
    cpu_wr(200, 4'hF, 32'h12345678);
    clr_req = 1; clr_char = 8'h2E;
    tick;
    clr_req = 0;
    repeat (100) tick;
    reset_n = 0;
    #1;
    check("rst_mid_busy", {31'b0, clr_busy}, 32'h0);
    tick; tick;
    reset_n = 1;
    tick;
    check("post_rst_ready", {31'b0, cpu_ready}, 32'h1);
    check("post_rst_busy", {31'b0, clr_busy}, 32'h0);
    cpu_rd("part_w0", 0, 32'h2E2E2E2E);
    cpu_rd("part_w99", 99, 32'h2E2E2E2E);
    cpu_rd("part_w100", 100, 32'h00000000);
    cpu_rd("part_w200", 200, 32'h12345678);

    // Full clear against a held CPU read.
    cpu_req = 1; cpu_we = 0; cpu_addr = 5; clr_req = 1; clr_char = 8'h2E;
    tick;
    clr_req = 0;
    busy_cnt = 0; ready_bad = 0; g = 0;
    while (clr_busy && g < 1000) begin
      if (cpu_ready) ready_bad++;
      busy_cnt++;
      tick;
      g++;
    end
    check("clr_busy_len", busy_cnt, 32'd480);
    check("ready_during_clear", ready_bad, 32'd0);
    check("ready_done_cycle", {31'b0, cpu_ready}, 32'h0);
    tick;
    check("ready_first_idle", {31'b0, cpu_ready}, 32'h1);
    tick;
    cpu_req = 0;
    check("held_rd_rvalid", {31'b0, cpu_rvalid}, 32'h1);
    check("held_rd", cpu_rdata, 32'h2E2E2E2E);
    cpu_rd("clr_w0", 0, 32'h2E2E2E2E);
    cpu_rd("clr_w200", 200, 32'h2E2E2E2E);
    cpu_rd("clr_w479", 479, 32'h2E2E2E2E);

`ifdef CMEM_CURSOR_EN
    cpu_wr(41, 4'b0010, 32'h00004100);
    cur_col = 5; cur_row = 2; cur_en = 1;
    force dut.blink_q = 24'h800000;
    force_blink = 1;
    vid_read("cursor_on", 5, 2, 8'hC1);
    cur_en = 0;
    vid_read("cursor_off", 5, 2, 8'h41);
    release dut.blink_q;
    force_blink = 0;
`endif

    repeat (4000) begin
      vid_en    = 1'($urandom);
      vid_col   = CW'($urandom_range(0, 83));
      vid_row   = RW'($urandom_range(0, 25));
      cpu_req   = 1'($urandom);
      cpu_we    = 1'($urandom);
      cpu_be    = 4'($urandom);
      cpu_addr  = AW'($urandom_range(0, 490));
      cpu_wdata = $urandom;
      scroll_we = ($urandom_range(0, 7) == 0);
      scroll_in = RW'($urandom_range(0, 25));
      clr_req   = ($urandom_range(0, 999) == 0);
      clr_char  = 8'($urandom);
      tick;
    end
    vid_en = 0; cpu_req = 0; scroll_we = 0; clr_req = 0;
    repeat (3) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
